// File: rtl/key_debounce_multi_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the multi-channel key debouncer.
//   KEY_IDLE / KEY_FILTER0 / KEY_DOWN / KEY_FILTER1 : one-hot filter states
//   cnt_width()                                     : counter width helper
// ---------------------------------------------------------------------------
package key_pkg;

    localparam logic [3:0] KEY_IDLE    = 4'b0001;
    localparam logic [3:0] KEY_FILTER0 = 4'b0010;
    localparam logic [3:0] KEY_DOWN    = 4'b0100;
    localparam logic [3:0] KEY_FILTER1 = 4'b1000;

    // Bits needed to hold values 0..n-1, never less than one bit so that a
    // degenerate counter still has a legal declaration.
    function automatic int cnt_width(input int unsigned n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_multi_chan.sv
// ---------------------------------------------------------------------------
// key_debounce_chan
// One debounced key channel: two-flop synchroniser, four-state filter FSM
// with abort-on-bounce, debounce counter and saturating long-press counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_i      : raw asynchronous pin
//   state_o    : debounced level, 1 = pressed
//   press_o    : one-cycle strobe when a press is accepted
//   release_o  : one-cycle strobe when a release is accepted
//   long_o     : one-cycle strobe, at most once per press
// ---------------------------------------------------------------------------
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int LW = cnt_width(LONG_CYCLES + 1);

    localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic          LONG_EN  = (LONG_CYCLES != 0);
    localparam logic [LW-1:0] L_LAST   = LONG_EN ? LW'(LONG_CYCLES - 1) : '0;
    localparam logic          RELEASED = ACTIVE_LOW;

    logic [1:0]    sync_q;
    logic          s;
    logic [3:0]    state_q,   state_d;
    logic [DW-1:0] dcnt_q,    dcnt_d;
    logic [LW-1:0] lcnt_q,    lcnt_d;
    logic          done_q,    done_d;
    logic          key_q,     key_d;
    logic          press_q,   press_d;
    logic          release_q, release_d;
    logic          long_q,    long_d;

    // Synchroniser resets to the released pin level so that leaving reset
    // never looks like a press edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RELEASED}};
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    assign s = sync_q[1] ^ RELEASED;

    // Filter FSM. The long-press counter only advances in DOWN, is frozen
    // through a FILTER1 bounce, and holds once done_q is set so it can never
    // wrap or fire a second time for the same press.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        lcnt_d    = lcnt_q;
        done_d    = done_q;
        key_d     = key_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            KEY_IDLE: begin
                if (s) begin
                    state_d = KEY_FILTER0;
                    dcnt_d  = '0;
                end
            end
            KEY_FILTER0: begin
                if (!s) begin
                    state_d = KEY_IDLE;
                end else if (dcnt_q == D_LAST) begin
                    state_d = KEY_DOWN;
                    key_d   = 1'b1;
                    press_d = 1'b1;
                    lcnt_d  = '0;
                    done_d  = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            KEY_DOWN: begin
                if (!s) begin
                    state_d = KEY_FILTER1;
                    dcnt_d  = '0;
                end else if (LONG_EN && !done_q) begin
                    if (lcnt_q == L_LAST) begin
                        long_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        lcnt_d = lcnt_q + LW'(1);
                    end
                end
            end
            KEY_FILTER1: begin
                if (s) begin
                    state_d = KEY_DOWN;
                end else if (dcnt_q == D_LAST) begin
                    state_d   = KEY_IDLE;
                    key_d     = 1'b0;
                    release_d = 1'b1;
                    done_d    = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = KEY_IDLE;
                key_d   = 1'b0;
                dcnt_d  = '0;
                lcnt_d  = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= KEY_IDLE;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            done_q    <= 1'b0;
            key_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            done_q    <= done_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign state_o   = key_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// ---------------------------------------------------------------------------
// key_debounce_multi
// N-channel push-button debouncer built from independent channels.
//   clk, rst_n    : clock, asynchronous active-low reset
//   key_in        : raw asynchronous key pins
//   key_state     : debounced level per channel, 1 = pressed
//   press_pulse   : one-cycle strobe per accepted press
//   release_pulse : one-cycle strobe per accepted release
//   long_pulse    : one-cycle long-press strobe, at most once per press
//   any_pressed   : OR of key_state
// ---------------------------------------------------------------------------
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic              any_pressed
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_i     (key_in[g]),
            .state_o   (key_state[g]),
            .press_o   (press_pulse[g]),
            .release_o (release_pulse[g]),
            .long_o    (long_pulse[g])
        );
    end

    assign any_pressed = |key_state;

endmodule

// File: tb/tb_key_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_multi
// Directed bench for key_debounce_multi. Instance A is active-low with a
// long-press window; instance B is active-high with long-press disabled.
// ---------------------------------------------------------------------------
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [3:0] keyA = 4'hF;
    logic [3:0] keyB = 4'h0;

    logic [3:0] stateA, pressA, relA, longA;
    logic       anyA;
    logic [3:0] stateB, pressB, relB, longB;
    logic       anyB;

    int nAssert = 0;
    int nFail   = 0;

    int pressCntA [4];
    int relCntA   [4];
    int longCntA  [4];
    int relCntB   [4];
    int longCntB  [4];

    int p1, r1, l2, r2;

    always #5 clk = ~clk;

    key_debounce_multi #(
        .N_KEYS          (4),
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (32),
        .ACTIVE_LOW      (1'b1)
    ) dutA (
        .clk           (clk),
        .rst_n         (rstN),
        .key_in        (keyA),
        .key_state     (stateA),
        .press_pulse   (pressA),
        .release_pulse (relA),
        .long_pulse    (longA),
        .any_pressed   (anyA)
    );

    key_debounce_multi #(
        .N_KEYS          (4),
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (0),
        .ACTIVE_LOW      (1'b0)
    ) dutB (
        .clk           (clk),
        .rst_n         (rstN),
        .key_in        (keyB),
        .key_state     (stateB),
        .press_pulse   (pressB),
        .release_pulse (relB),
        .long_pulse    (longB),
        .any_pressed   (anyB)
    );

    // Pulse tallies sampled on the rising edge, so a count read on a falling
    // edge covers every cycle that has already completed.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pressA[i] === 1'b1) pressCntA[i]++;
            if (relA[i]   === 1'b1) relCntA[i]++;
            if (longA[i]  === 1'b1) longCntA[i]++;
            if (relB[i]   === 1'b1) relCntB[i]++;
            if (longB[i]  === 1'b1) longCntB[i]++;
        end
    end

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input int cycles);
        keyA = a;
        keyB = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAssert++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(4'hF, 4'h0, 3);
        checkOutput("rst_stateA",   32'(stateA), 32'h0);
        checkOutput("rst_pressA",   32'(pressA), 32'h0);
        checkOutput("rst_relA",     32'(relA),   32'h0);
        checkOutput("rst_longA",    32'(longA),  32'h0);
        checkOutput("rst_anyA",     32'(anyA),   32'h0);
        checkOutput("rst_stateB",   32'(stateB), 32'h0);
        rstN = 1'b1;
        applyStimulus(4'hF, 4'h0, 5);
        checkOutput("post_rst_stateA", 32'(stateA), 32'h0);
        checkOutput("post_rst_pressA", 32'(pressCntA[0] + pressCntA[1] + pressCntA[2] + pressCntA[3]), 32'h0);

        // Clean press and release on channel 0
        applyStimulus(4'hE, 4'h0, 10);
        checkOutput("press0_early", 32'(pressA), 32'h0);
        checkOutput("state0_early", 32'(stateA), 32'h0);
        applyStimulus(4'hE, 4'h0, 1);
        checkOutput("press0_hit",   32'(pressA), 32'h1);
        checkOutput("state0_hit",   32'(stateA), 32'h1);
        checkOutput("any0_hit",     32'(anyA),   32'h1);
        applyStimulus(4'hE, 4'h0, 1);
        checkOutput("press0_after", 32'(pressA), 32'h0);
        checkOutput("state0_held",  32'(stateA), 32'h1);
        applyStimulus(4'hE, 4'h0, 18);
        applyStimulus(4'hF, 4'h0, 10);
        checkOutput("rel0_early",   32'(relA),   32'h0);
        checkOutput("state0_still", 32'(stateA), 32'h1);
        applyStimulus(4'hF, 4'h0, 1);
        checkOutput("rel0_hit",     32'(relA),   32'h1);
        checkOutput("state0_rel",   32'(stateA), 32'h0);
        checkOutput("any0_rel",     32'(anyA),   32'h0);
        applyStimulus(4'hF, 4'h0, 1);
        checkOutput("rel0_after",   32'(relA),   32'h0);
        checkOutput("long0_none",   32'(longCntA[0]), 32'h0);

        // Bounce rejection on channel 1, then a genuine 20-cycle press
        p1 = pressCntA[1];
        r1 = relCntA[1];
        applyStimulus(4'hD, 4'h0, 5);
        applyStimulus(4'hF, 4'h0, 5);
        applyStimulus(4'hD, 4'h0, 3);
        applyStimulus(4'hF, 4'h0, 15);
        checkOutput("bounce1_press", 32'(pressCntA[1] - p1), 32'h0);
        checkOutput("bounce1_rel",   32'(relCntA[1] - r1),   32'h0);
        checkOutput("bounce1_state", 32'(stateA), 32'h0);
        applyStimulus(4'hD, 4'h0, 10);
        checkOutput("press1_early", 32'(pressA), 32'h0);
        applyStimulus(4'hD, 4'h0, 1);
        checkOutput("press1_hit",   32'(pressA), 32'h2);
        applyStimulus(4'hD, 4'h0, 9);
        applyStimulus(4'hF, 4'h0, 12);
        checkOutput("press1_count", 32'(pressCntA[1] - p1), 32'h1);
        checkOutput("rel1_count",   32'(relCntA[1] - r1),   32'h1);
        checkOutput("state1_rel",   32'(stateA), 32'h0);

        // Long press on channel 2 with a short release bounce inside DOWN
        l2 = longCntA[2];
        r2 = relCntA[2];
        applyStimulus(4'hB, 4'h0, 10);
        checkOutput("press2_early", 32'(pressA), 32'h0);
        applyStimulus(4'hB, 4'h0, 1);
        checkOutput("press2_hit",   32'(pressA), 32'h4);
        applyStimulus(4'hB, 4'h0, 31);
        checkOutput("long2_early",  32'(longA),  32'h0);
        applyStimulus(4'hB, 4'h0, 1);
        checkOutput("long2_hit",    32'(longA),  32'h4);
        checkOutput("long2_excl",   32'(pressA | relA), 32'h0);
        applyStimulus(4'hB, 4'h0, 1);
        checkOutput("long2_after",  32'(longA),  32'h0);
        applyStimulus(4'hF, 4'h0, 4);
        applyStimulus(4'hB, 4'h0, 20);
        checkOutput("bounce2_state", 32'(stateA), 32'h4);
        checkOutput("bounce2_rel",   32'(relCntA[2] - r2),  32'h0);
        checkOutput("bounce2_long",  32'(longCntA[2] - l2), 32'h1);
        applyStimulus(4'hF, 4'h0, 16);
        checkOutput("rel2_count",   32'(relCntA[2] - r2),  32'h1);
        checkOutput("long2_once",   32'(longCntA[2] - l2), 32'h1);
        checkOutput("state2_rel",   32'(stateA), 32'h0);

        // All four channels pressed in the same cycle
        applyStimulus(4'h0, 4'h0, 10);
        checkOutput("all_early",    32'(pressA), 32'h0);
        checkOutput("all_any_early", 32'(anyA),  32'h0);
        applyStimulus(4'h0, 4'h0, 1);
        checkOutput("all_press",    32'(pressA), 32'hF);
        checkOutput("all_state",    32'(stateA), 32'hF);
        checkOutput("all_any",      32'(anyA),   32'h1);
        applyStimulus(4'hF, 4'h0, 12);
        checkOutput("all_released", 32'(stateA), 32'h0);
        checkOutput("all_any_off",  32'(anyA),   32'h0);

        // Active-high instance with long-press disabled
        applyStimulus(4'hF, 4'h8, 10);
        checkOutput("b_press_early", 32'(pressB), 32'h0);
        applyStimulus(4'hF, 4'h8, 1);
        checkOutput("b_press_hit",  32'(pressB), 32'h8);
        checkOutput("b_state_hit",  32'(stateB), 32'h8);
        checkOutput("b_any_hit",    32'(anyB),   32'h1);
        applyStimulus(4'hF, 4'h8, 99);
        checkOutput("b_state_held", 32'(stateB), 32'h8);
        checkOutput("b_long_none",  32'(longCntB[3]), 32'h0);
        applyStimulus(4'hF, 4'h0, 12);
        checkOutput("b_state_rel",  32'(stateB), 32'h0);
        checkOutput("b_rel_count",  32'(relCntB[3]), 32'h1);

        // Reset while channel 0 is mid-filter and channel 1 is pressed
        applyStimulus(4'hD, 4'h0, 12);
        checkOutput("pre_rst_state", 32'(stateA), 32'h2);
        applyStimulus(4'hC, 4'h0, 8);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_state", 32'(stateA), 32'h0);
        checkOutput("midrst_any",   32'(anyA),   32'h0);
        checkOutput("midrst_pulses", 32'(pressA | relA | longA), 32'h0);
        applyStimulus(4'hC, 4'h0, 2);
        rstN = 1'b1;
        applyStimulus(4'hC, 4'h0, 10);
        checkOutput("rerst_early",  32'(pressA), 32'h0);
        checkOutput("rerst_state0", 32'(stateA), 32'h0);
        applyStimulus(4'hC, 4'h0, 1);
        checkOutput("rerst_press",  32'(pressA), 32'h3);
        checkOutput("rerst_state",  32'(stateA), 32'h3);
        applyStimulus(4'hF, 4'h0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
